// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl: load/store sequencer between core and data memory.
// Formats store lanes/strobes, aligns and extends load data, stalls the core.
`default_nettype none

module dmem_access_ctrl #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ready,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        wb_sel,
  output logic [31:0] load_data,
  output logic        done,
  output logic        err
);

  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 2);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2, DONE = 2'd3} state_t;

  state_t         state_q;
  logic [CW-1:0]  cnt_q;
  logic           we_q;
  logic [2:0]     funct3_q;
  logic [1:0]     lane_q;
  logic           mem_req_q, mem_we_q, wb_sel_q, done_q, err_q;
  logic [31:0]    mem_addr_q, mem_wdata_q, load_data_q;
  logic [3:0]     mem_wstrb_q;

  logic           legal;
  logic           timeout_hit;
  logic [31:0]    st_wdata_d;
  logic [3:0]     st_wstrb_d;
  logic [31:0]    ld_fmt_d;
  logic [7:0]     ld_byte;
  logic [15:0]    ld_half;

  always_comb begin
    legal = 1'b0;
    case (funct3)
      3'b000:         legal = 1'b1;
      3'b001:         legal = ~addr[0];
      3'b010:         legal = (addr[1:0] == 2'b00);
      3'b100:         legal = ~req_we;
      3'b101:         legal = ~req_we & ~addr[0];
      default:        legal = 1'b0;
    endcase
  end

  always_comb begin
    st_wdata_d = wdata;
    st_wstrb_d = 4'b1111;
    case (funct3[1:0])
      2'b00: begin
        st_wdata_d = {4{wdata[7:0]}};
        st_wstrb_d = 4'b0001 << addr[1:0];
      end
      2'b01: begin
        st_wdata_d = {2{wdata[15:0]}};
        st_wstrb_d = 4'b0011 << addr[1:0];
      end
      default: begin
        st_wdata_d = wdata;
        st_wstrb_d = 4'b1111;
      end
    endcase
  end

  // Formatting uses the latched lane/funct3 so the core may change inputs after DONE.
  always_comb begin
    ld_byte  = mem_rdata[8*lane_q +: 8];
    ld_half  = lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    ld_fmt_d = mem_rdata;
    case (funct3_q)
      3'b000:  ld_fmt_d = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_fmt_d = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_fmt_d = {24'b0, ld_byte};
      3'b101:  ld_fmt_d = {16'b0, ld_half};
      default: ld_fmt_d = mem_rdata;
    endcase
  end

  assign timeout_hit = (cnt_q == CNT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      funct3_q    <= 3'b0;
      lane_q      <= 2'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'b0;
      mem_wdata_q <= 32'b0;
      mem_wstrb_q <= 4'b0;
      load_data_q <= 32'b0;
      wb_sel_q    <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      wb_sel_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_valid && legal) begin
            state_q     <= REQ;
            cnt_q       <= '0;
            we_q        <= req_we;
            funct3_q    <= funct3;
            lane_q      <= addr[1:0];
            mem_req_q   <= 1'b1;
            mem_we_q    <= req_we;
            mem_addr_q  <= {addr[31:2], 2'b00};
            mem_wdata_q <= req_we ? st_wdata_d : 32'b0;
            mem_wstrb_q <= req_we ? st_wstrb_d : 4'b0;
          end else if (req_valid) begin
            done_q <= 1'b1;
            err_q  <= 1'b1;
          end
        end
        REQ: begin
          cnt_q <= cnt_q + 1'b1;
          if (mem_ready || timeout_hit) begin
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_wstrb_q <= 4'b0;
          end
          if (mem_ready && we_q) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end else if (mem_ready && mem_rvalid) begin
            state_q     <= DONE;
            done_q      <= 1'b1;
            wb_sel_q    <= 1'b1;
            load_data_q <= ld_fmt_d;
          end else if (timeout_hit) begin
            state_q <= DONE;
            done_q  <= 1'b1;
            err_q   <= 1'b1;
          end else if (mem_ready) begin
            state_q <= WAIT;
          end
        end
        WAIT: begin
          cnt_q <= cnt_q + 1'b1;
          if (mem_rvalid) begin
            state_q     <= DONE;
            done_q      <= 1'b1;
            wb_sel_q    <= 1'b1;
            load_data_q <= ld_fmt_d;
          end else if (timeout_hit) begin
            state_q <= DONE;
            done_q  <= 1'b1;
            err_q   <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy      = (state_q == REQ) || (state_q == WAIT) ||
                     ((state_q == IDLE) && req_valid && legal);
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wstrb = mem_wstrb_q;
  assign wb_sel    = wb_sel_q;
  assign load_data = load_data_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

`default_nettype wire

// File: tb/tb_dmem_access_ctrl.sv
// tb_dmem_access_ctrl: directed + randomized checks of dmem_access_ctrl
// against an arithmetic model of legality, lane formatting and timeout.
`default_nettype none

module tb_dmem_access_ctrl;

  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_we;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata;
  logic        busy, mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready, mem_rvalid;
  logic [31:0] mem_rdata;
  logic        wb_sel, done, err;
  logic [31:0] load_data;

  int          total = 0;
  int          bad   = 0;
  logic [31:0] exp_ld = 32'b0;

  dmem_access_ctrl #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we), .funct3(funct3),
    .addr(addr), .wdata(wdata), .busy(busy), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .wb_sel(wb_sel), .load_data(load_data), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit is_legal(input bit we, input logic [2:0] f3, input logic [31:0] a);
    bit ok;
    int size;
    if (we) ok = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2);
    else    ok = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    size = 1 << f3[1:0];
    return ok && ((int'(a[1:0]) % size) == 0);
  endfunction

  function automatic logic [3:0] exp_strb(input logic [2:0] f3, input logic [31:0] a);
    int size = 1 << f3[1:0];
    int m = (1 << size) - 1;
    return 4'(m << int'(a[1:0]));
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [2:0] f3, input logic [31:0] w);
    logic [31:0] r;
    int size = 1 << f3[1:0];
    for (int i = 0; i < 4; i++) r[8*i +: 8] = w[8*(i % size) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] rd);
    int size = 1 << f3[1:0];
    int bits = 8 * size;
    int off  = (int'(a[1:0]) / size) * size;
    logic [31:0] mask = 32'hFFFF_FFFF >> (32 - bits);
    logic [31:0] v = (rd >> (8 * off)) & mask;
    if (!f3[2] && v[bits-1]) v = v | ~mask;
    return v;
  endfunction

  // One complete access; rdy = cycle index (from first REQ cycle) of mem_ready,
  // rvd = extra cycles until mem_rvalid for loads (0 = same cycle as ready).
  task automatic access(input string tag, input bit we, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] w, input logic [31:0] rd,
                        input int rdy, input int rvd);
    bit legal;
    bit ok;
    int comp;
    int endk;
    legal      = is_legal(we, f3, a);
    req_valid  = 1'b1;
    req_we     = we;
    funct3     = f3;
    addr       = a;
    wdata      = w;
    mem_rdata  = rd;
    mem_ready  = 1'b0;
    mem_rvalid = 1'b0;
    #1;
    chk({tag, ":busy_idle"}, busy, legal);
    if (!legal) begin
      tick();
      chk({tag, ":err_done"}, done, 1);
      chk({tag, ":err_err"}, err, 1);
      chk({tag, ":err_memreq"}, mem_req, 0);
      chk({tag, ":err_busy"}, busy, 0);
      chk({tag, ":err_wbsel"}, wb_sel, 0);
      req_valid = 1'b0;
      tick();
      chk({tag, ":err_done_clr"}, done, 0);
      chk({tag, ":err_memreq2"}, mem_req, 0);
      return;
    end
    comp = we ? rdy : rdy + rvd;
    ok   = (comp <= TIMEOUT - 2);
    endk = ok ? comp : TIMEOUT - 2;
    tick();
    for (int k = 0; k <= endk; k++) begin
      chk({tag, ":memreq"}, mem_req, (k <= rdy));
      chk({tag, ":busy"}, busy, 1);
      chk({tag, ":done_lo"}, done, 0);
      chk({tag, ":wbsel_lo"}, wb_sel, 0);
      if (k <= rdy) begin
        chk({tag, ":addr"}, mem_addr, {a[31:2], 2'b00});
        chk({tag, ":we"}, mem_we, we);
        chk({tag, ":wstrb"}, mem_wstrb, we ? exp_strb(f3, a) : 4'b0);
        if (we) chk({tag, ":wdata"}, mem_wdata, exp_wdata(f3, w));
      end
      mem_ready  = (k == rdy);
      mem_rvalid = !we && (k == rdy + rvd);
      tick();
    end
    mem_ready  = 1'b0;
    mem_rvalid = 1'b0;
    if (ok && !we) exp_ld = exp_load(f3, a, rd);
    chk({tag, ":done"}, done, 1);
    chk({tag, ":err"}, err, !ok);
    chk({tag, ":wbsel"}, wb_sel, ok && !we);
    chk({tag, ":memreq_done"}, mem_req, 0);
    chk({tag, ":busy_done"}, busy, 0);
    chk({tag, ":load_data"}, load_data, exp_ld);
    req_valid = 1'b0;
    tick();
    chk({tag, ":done_clr"}, done, 0);
    chk({tag, ":wbsel_clr"}, wb_sel, 0);
    chk({tag, ":ld_hold"}, load_data, exp_ld);
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; funct3 = 3'b0; addr = 32'b0; wdata = 32'b0;
    mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'b0;
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("rst:memreq", mem_req, 0);
    chk("rst:busy", busy, 0);
    chk("rst:done", done, 0);
    chk("rst:err", err, 0);
    chk("rst:wbsel", wb_sel, 0);
    chk("rst:load_data", load_data, 0);
    chk("rst:wstrb", mem_wstrb, 0);

    access("sw",   1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 0, 0);
    access("lb",   1'b0, 3'b000, 32'h13, 32'h0, 32'h80FF_0000, 0, 3);
    access("sh",   1'b1, 3'b001, 32'h22, 32'h1234, 32'h0, 1, 0);
    access("lhu",  1'b0, 3'b101, 32'h22, 32'h0, 32'hABCD_0000, 2, 0);
    access("lwmis",1'b0, 3'b010, 32'h05, 32'h0, 32'h0, 0, 0);
    access("lwto", 1'b0, 3'b010, 32'h40, 32'h0, 32'h1111_2222, 99, 0);

    // Reset while the load sits in WAIT; late read data must not land.
    req_valid = 1'b1; req_we = 1'b0; funct3 = 3'b010; addr = 32'h44;
    tick();
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    tick();
    #2;
    rst = 1'b1;
    req_valid = 1'b0;
    #1;
    exp_ld = 32'b0;
    chk("arst:memreq", mem_req, 0);
    chk("arst:busy", busy, 0);
    chk("arst:done", done, 0);
    chk("arst:load_data", load_data, 0);
    chk("arst:addr", mem_addr, 0);
    tick();
    rst = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata = 32'h1234_5678;
    tick();
    mem_rvalid = 1'b0;
    chk("late:done", done, 0);
    chk("late:wbsel", wb_sel, 0);
    chk("late:load_data", load_data, 0);
    access("lw_after", 1'b0, 3'b010, 32'h44, 32'h0, 32'hCAFE_F00D, 1, 1);

    for (int i = 0; i < 60; i++) begin
      bit          we   = 1'($urandom_range(0, 1));
      logic [2:0]  f3   = 3'($urandom_range(0, 7));
      logic [31:0] a    = $urandom;
      logic [31:0] w    = $urandom;
      logic [31:0] rd   = $urandom;
      int          rdy  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(10, 20))
                                                      : int'($urandom_range(0, 3));
      int          rvd  = int'($urandom_range(0, 4));
      access($sformatf("rnd%0d", i), we, f3, a, w, rd, rdy, rvd);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
